// File: rtl/flash_word_fetch_pkg.sv
// Shared SPI flash definitions.
//   FLASH_ADDR_W   : width of a flash byte address
//   FLASH_CMD_READ : SPI READ opcode issued by the downstream byte engine
//   fetch_state_e  : word-fetch sequencer states
package flash_word_fetch_pkg;

  localparam int unsigned FLASH_ADDR_W   = 24;
  localparam logic [7:0]  FLASH_CMD_READ = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } fetch_state_e;

endpackage

// File: rtl/flash_word_fetch.sv
// Word-fetch sequencer sitting in front of the SPI flash byte-read engine.
// Takes one word request (byte address), issues NBYTES single-byte reads
// at base, base+1, ... (24-bit wrap), packs them little-endian into a
// 32-bit word and returns it on a valid/ready channel.
//
// Ports:
//   clock_12MHz, reset          : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr: word request channel (ready only in IDLE)
//   resp_valid/resp_ready/resp_data : assembled word response channel
//   read_strobe/read_addr       : one-cycle byte read command to the engine
//   read_data/read_busy         : engine byte result and busy flag
module flash_word_fetch
  import flash_word_fetch_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                    clock_12MHz,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FLASH_ADDR_W-1:0] req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic                    read_strobe,
  output logic [FLASH_ADDR_W-1:0] read_addr,
  input  logic [7:0]              read_data,
  input  logic                    read_busy
);

  localparam logic [1:0] LAST_K = 2'(NBYTES - 1);

  fetch_state_e            state_q;
  logic [1:0]              k_q;
  logic [FLASH_ADDR_W-1:0] base_q;
  logic [31:0]             word_q;
  logic                    skip_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    read_strobe_q;
  logic [FLASH_ADDR_W-1:0] read_addr_q;

  always_ff @(posedge clock_12MHz) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      base_q        <= '0;
      word_q        <= '0;
      skip_q        <= 1'b0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      read_strobe_q <= 1'b0;
      read_addr_q   <= '0;
    end else begin
      read_strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // req_ready is registered, so it comes up one cycle after
          // entering IDLE (reset exit) or together with it (response handshake).
          if (req_valid && req_ready_q) begin
            base_q      <= req_addr;
            k_q         <= '0;
            word_q      <= '0;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ISSUE: begin
          // Engine is not reset with us and may still be finishing an
          // earlier transfer; only strobe once it reports idle.
          if (!read_busy) begin
            read_strobe_q <= 1'b1;
            read_addr_q   <= base_q + {{(FLASH_ADDR_W-2){1'b0}}, k_q};
            skip_q        <= 1'b1;
            state_q       <= WAIT;
          end
        end

        WAIT: begin
          // Busy only rises the cycle after the engine sees the strobe, so
          // the first WAIT cycle would see a stale idle; ignore it.
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (!read_busy) begin
            word_q[{k_q, 3'b000} +: 8] <= read_data;
            if (k_q == LAST_K) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              k_q     <= k_q + 2'd1;
              state_q <= ISSUE;
            end
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = word_q;
  assign read_strobe = read_strobe_q;
  assign read_addr   = read_addr_q;

endmodule

// File: doc/flash_word_fetch.md
Name: flash_word_fetch

Overview:
- Request-side sequencer directly upstream of the SPI flash byte-read engine.
- Accepts one word-read request (24-bit byte address) from the CPU/boot logic.
- Issues NBYTES consecutive single-byte reads to the engine over its strobe/addr/busy/data interface, assembles the bytes little-endian into a 32-bit word, and returns it on a valid/ready response channel.

Parameters:
- NBYTES, 4, bytes per word fetch; legal range 1..4. Unused upper bytes of resp_data are 0.

Ports:
- clock_12MHz  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_addr  in  24  byte address of the first (least significant) byte.
- resp_valid  out  1  assembled word available.
- resp_ready  in  1  consumer accepts the word.
- resp_data  out  32  assembled word; byte k = flash[req_addr+k].
- read_strobe  out  1  one-cycle pulse to the byte engine.
- read_addr  out  24  byte address to the engine; valid while read_strobe=1.
- read_data  in  8  byte from the engine; valid when read_busy=0 after a read.
- read_busy  in  1  engine busy. Rises the cycle after an accepted strobe and falls when the byte is ready.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, resp_valid=0, resp_data=0, read_strobe=0, read_addr=0.
  - Internals: state=IDLE, byte index k=0, addr register=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_addr, set k=0, clear the word register to 0, go to ISSUE.
- ISSUE:
  - If read_busy=0, drive read_strobe=1 for exactly one cycle with read_addr=base+k, then go to WAIT.
  - If read_busy=1 (the engine is not reset by this block and may still be finishing a transfer after reset), hold in ISSUE with read_strobe=0.
- WAIT:
  - The first WAIT cycle is always skipped: busy is not sampled on the cycle immediately after the strobe.
  - From the second cycle on, when read_busy=0, write read_data into byte lane k.
  - Then: if k==NBYTES-1, go to RESP; otherwise increment k and go to ISSUE.
- RESP:
  - resp_valid=1 and resp_data holds stable until resp_valid&&resp_ready, then go to IDLE.
  - Back-to-back requests: req_ready rises the cycle after the handshake.
- Address arithmetic: base+k is 24-bit modulo 2^24. A request at 24'hFFFFFE with NBYTES=4 reads FFFFFE, FFFFFF, 000000, 000001.
- Latency:
  - Each byte costs 1 (ISSUE) + the engine transfer time + 1.
  - RESP is entered the cycle after the last byte is captured.
  - No combinational path from req_* to resp_*.
- read_strobe is never asserted outside ISSUE, and never twice for one byte.
- req_valid while busy (not IDLE) is ignored; the request must be held by the requester until req_ready.
- reset mid-operation:
  - The block returns to IDLE next cycle and any partial word is discarded.
  - read_strobe drops immediately.
  - The next request waits in ISSUE until read_busy=0.
- Simultaneous reset and req_valid: reset wins; the request is not accepted.

Decomposition:
- Shared flash package holds:
  - FLASH_ADDR_W=24, FLASH_CMD_READ=8'h03.
  - State enumeration constants IDLE/ISSUE/WAIT/RESP.
- No sub-module needed. An optional byte-lane assembler is small enough to stay inline.

Test Plan:
- Basic fetch: req_addr=24'h000100, flash bytes 11,22,33,44 from a behavioural engine model -> exactly 4 strobes at 000100..000103; resp_data=32'h44332211; resp_valid high until resp_ready.
- Backpressure: hold resp_ready=0 for 20 cycles -> resp_valid and resp_data stable throughout; req_ready=0; no extra strobes; the handshake returns the block to IDLE.
- Wrap-around: req_addr=24'hFFFFFE -> strobe addresses FFFFFE, FFFFFF, 000000, 000001 in order.
- Busy at start: model holds read_busy=1 for 50 cycles after reset while a request arrives -> request accepted; first strobe only after read_busy=0.
- Reset mid-fetch: assert reset after the 2nd byte's strobe -> read_strobe=0 and resp_valid=0 next cycle. A new request to 000200 then returns the correct word, with no stale bytes.
- NBYTES=2 build: req_addr=000010, bytes AA,BB -> 2 strobes; resp_data=32'h0000BBAA.
